// File: rtl/ishift_arbiter.sv
// Round-robin front end sharing one iterative shifter among NREQ requesters.
// Grants one requester, issues a single go pulse and returns the result with a done strobe.
module ishift_arbiter #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 2
) (
   input  logic                    clk_i,
   input  logic                    arst_i,
   input  logic [NREQ-1:0]         req_i,
   input  logic [3*NREQ-1:0]       fmt_i,
   input  logic [6*NREQ-1:0]       cnt_i,
   input  logic [WIDTH*NREQ-1:0]   a_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [NREQ-1:0]         done_o,
   output logic [WIDTH-1:0]        y_o,
   output logic                    busy_o,
   output logic                    sh_go_o,
   output logic [2:0]              sh_fmt_o,
   output logic [5:0]              sh_cnt_o,
   output logic [WIDTH-1:0]        sh_a_o,
   input  logic                    sh_busy_i,
   input  logic [WIDTH-1:0]        sh_y_i
);

   localparam int PW = $clog2(NREQ);
   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT
   } state_e;

   state_e            state_q;
   logic [PW-1:0]     ptr_q;
   logic [PW-1:0]     win;
   logic [NREQ-1:0]   done_q;
   logic              go_q;
   logic [WIDTH-1:0]  y_q;
   logic [2:0]        fmt_q;
   logic [5:0]        cnt_q;
   logic [WIDTH-1:0]  a_q;

   // Scan from the farthest slot back to ptr+1 so the nearest hit wins.
   always_comb begin
      win = ptr_q;
      for (int i = NREQ; i >= 1; i--) begin
         int j;
         j = int'(ptr_q) + i;
         if (j >= NREQ) j = j - NREQ;
         if (req_i[j]) win = PW'(j);
      end
   end

   assign gnt_o = (state_q == IDLE && !arst_i && req_i != '0)
                  ? (ONE << win) : '0;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q <= IDLE;
         ptr_q   <= PW'(NREQ - 1);
         done_q  <= '0;
         go_q    <= 1'b0;
         y_q     <= '0;
         fmt_q   <= '0;
         cnt_q   <= '0;
         a_q     <= '0;
      end else begin
         done_q <= '0;
         go_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (req_i != '0) begin
                  ptr_q   <= win;
                  fmt_q   <= fmt_i[3*int'(win) +: 3];
                  cnt_q   <= cnt_i[6*int'(win) +: 6];
                  a_q     <= a_i[WIDTH*int'(win) +: WIDTH];
                  go_q    <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               state_q <= WAIT;
            end
            WAIT: begin
               // The shifter raises busy on the edge that sees go, so it is valid here.
               if (!sh_busy_i) begin
                  y_q     <= sh_y_i;
                  done_q  <= ONE << ptr_q;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign done_o   = done_q;
   assign y_o      = y_q;
   assign busy_o   = (state_q != IDLE);
   assign sh_go_o  = go_q;
   assign sh_fmt_o = fmt_q;
   assign sh_cnt_o = cnt_q;
   assign sh_a_o   = a_q;

endmodule

// File: tb/tb_ishift_arbiter.sv
// Bench for ishift_arbiter: shifter stub, transaction-level reference model
// and directed vectors with hand-computed results and latencies.
module tb_ishift_arbiter;

   localparam int W = 32;
   localparam int N = 2;

   logic           clk = 1'b0;
   logic           arst;
   logic [N-1:0]   req;
   logic [3*N-1:0] fmt;
   logic [6*N-1:0] cnt;
   logic [W*N-1:0] a;
   logic [N-1:0]   gnt, done;
   logic [W-1:0]   y;
   logic           busy, sh_go;
   logic [2:0]     sh_fmt;
   logic [5:0]     sh_cnt;
   logic [W-1:0]   sh_a;
   logic           sh_busy;
   logic [W-1:0]   sh_y;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   ishift_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk_i(clk), .arst_i(arst), .req_i(req), .fmt_i(fmt),
      .cnt_i(cnt), .a_i(a), .gnt_o(gnt), .done_o(done), .y_o(y),
      .busy_o(busy), .sh_go_o(sh_go), .sh_fmt_o(sh_fmt),
      .sh_cnt_o(sh_cnt), .sh_a_o(sh_a), .sh_busy_i(sh_busy),
      .sh_y_i(sh_y)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // 000 lsr, 001 lsl, 010 asr, 011 rol, 100 ror, others pass
   function automatic logic [W-1:0] shf(input logic [2:0] f,
                                        input logic [5:0] c,
                                        input logic [W-1:0] v);
      logic [W-1:0] r;
      int rc;
      rc = int'(c) % W;
      case (f)
         3'b000:  r = v >> c;
         3'b001:  r = v << c;
         3'b010:  r = $signed(v) >>> c;
         3'b011:  r = (v << rc) | (v >> (W - rc));
         3'b100:  r = (v >> rc) | (v << (W - rc));
         default: r = v;
      endcase
      return r;
   endfunction

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
      end
   endtask

   // Iterative shifter stub: busy for k+1 cycles, k = cnt/6 + cnt%6
   logic [2:0]   s_f;
   logic [5:0]   s_c;
   logic [W-1:0] s_a;
   int           s_rem;
   always @(posedge clk or posedge arst) begin
      if (arst) begin
         sh_busy <= 1'b0;
         sh_y    <= '0;
         s_rem   <= 0;
      end else if (sh_go && !sh_busy) begin
         s_f     <= sh_fmt;
         s_c     <= sh_cnt;
         s_a     <= sh_a;
         sh_y    <= sh_a;
         sh_busy <= (sh_cnt != 0);
         s_rem   <= int'(sh_cnt) / 6 + int'(sh_cnt) % 6;
      end else if (sh_busy) begin
         if (s_rem == 0) begin
            sh_busy <= 1'b0;
            sh_y    <= shf(s_f, s_c, s_a);
         end else begin
            s_rem <= s_rem - 1;
         end
      end
   end

   // Reference model: one op in flight, done scheduled from grant time
   bit           op_act;
   int           op_start, op_done, m_owner, m_ptr;
   logic [W-1:0] m_y, m_ypend, m_a;
   logic [2:0]   m_f;
   logic [5:0]   m_c;

   always @(negedge clk) begin : cmp
      logic [N-1:0] eg, ed;
      logic         eb, ego;
      int           w;
      if (arst) begin
         op_act = 0;
         m_ptr  = N - 1;
         m_y    = '0;
         check("rst_gnt", gnt, 0);
         check("rst_done", done, 0);
         check("rst_busy", busy, 0);
         check("rst_go", sh_go, 0);
         check("rst_y", y, 0);
      end else begin
         eb  = op_act && cyc > op_start && cyc < op_done;
         ego = op_act && cyc == op_start + 1;
         ed  = '0;
         if (op_act && cyc == op_done) begin
            ed     = N'(1) << m_owner;
            m_y    = m_ypend;
            op_act = 0;
         end
         eg = '0;
         w  = -1;
         if (!op_act && req != '0) begin
            for (int i = 1; i <= N; i++) begin
               int j;
               j = (m_ptr + i) % N;
               if (req[j] && w < 0) w = j;
            end
            eg = N'(1) << w;
         end
         check("gnt", gnt, eg);
         check("done", done, ed);
         check("y", y, m_y);
         check("busy", busy, eb);
         check("sh_go", sh_go, ego);
         check("go_while_busy", sh_go & sh_busy, 0);
         check("gnt_onehot0", $countones(gnt) <= 1, 1);
         check("done_onehot0", $countones(done) <= 1, 1);
         if (eb) begin
            check("sh_fmt", sh_fmt, m_f);
            check("sh_cnt", sh_cnt, m_c);
            check("sh_a", sh_a, m_a);
         end
         if (w >= 0) begin
            op_act   = 1;
            op_start = cyc;
            m_owner  = w;
            m_ptr    = w;
            m_f      = fmt[3*w +: 3];
            m_c      = cnt[6*w +: 6];
            m_a      = a[W*w +: W];
            op_done  = cyc + ((m_c == 0) ? 3
                       : 4 + int'(m_c) / 6 + int'(m_c) % 6);
            m_ypend  = shf(m_f, m_c, m_a);
         end
      end
   end

   task automatic run_op(input int idx, input logic [2:0] f,
                         input logic [5:0] c, input logic [W-1:0] v,
                         input logic [W-1:0] ey, input int elat);
      int t, d;
      @(posedge clk) #1;
      fmt[3*idx +: 3] = f;
      cnt[6*idx +: 6] = c;
      a[W*idx +: W]   = v;
      req[idx]        = 1'b1;
      t = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (gnt[idx]) begin
            t = cyc;
            break;
         end
      end
      check("gnt_seen", t >= 0, 1);
      @(posedge clk) #1;
      req[idx] = 1'b0;
      if (t < 0) return;
      d = -1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (done[idx]) begin
            d = cyc;
            break;
         end
      end
      check("done_lat", d - t, elat);
      check("done_y", y, ey);
   endtask

   task automatic pulse_reset();
      @(posedge clk) #1;
      arst = 1'b1;
      @(negedge clk);
      @(posedge clk) #1;
      arst = 1'b0;
   endtask

   initial begin
      logic [N-1:0] gq[4];
      bit           dq[4];
      int           ng;
      arst = 1'b1;
      req  = '0;
      fmt  = '0;
      cnt  = '0;
      a    = '0;
      repeat (3) @(posedge clk);
      #1 arst = 1'b0;

      check("pin_asr", shf(3'b010, 6'd4, 32'h8000_0000), 32'hF800_0000);
      check("pin_lsl", shf(3'b001, 6'd31, 32'h1), 32'h8000_0000);
      check("pin_ror", shf(3'b100, 6'd8, 32'hFF), 32'hFF00_0000);
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_y", y, 0);

      run_op(0, 3'b010, 6'd4, 32'h8000_0000, 32'hF800_0000, 8);
      run_op(1, 3'b001, 6'd31, 32'h0000_0001, 32'h8000_0000, 10);
      run_op(0, 3'b100, 6'd8, 32'h0000_00FF, 32'hFF00_0000, 7);
      run_op(0, 3'b000, 6'd0, 32'h0000_1234, 32'h0000_1234, 3);
      run_op(1, 3'b011, 6'd12, 32'h8000_0001, 32'h0000_1800, 6);

      pulse_reset();
      fmt = {3'b000, 3'b001};
      cnt = {6'd2, 6'd1};
      a   = {32'h0000_0100, 32'h0000_0003};
      @(posedge clk) #1;
      req = 2'b11;
      ng  = 0;
      for (int n = 0; n < 200 && ng < 4; n++) begin
         @(negedge clk);
         if (gnt != '0) begin
            gq[ng] = gnt;
            dq[ng] = (done != '0);
            ng++;
         end
      end
      @(posedge clk) #1;
      req = '0;
      check("rr_count", ng, 4);
      check("rr_g0", gq[0], 2'b01);
      check("rr_g1", gq[1], 2'b10);
      check("rr_g2", gq[2], 2'b01);
      check("rr_g3", gq[3], 2'b10);
      check("rr_b2b1", dq[1], 1);
      check("rr_b2b2", dq[2], 1);
      check("rr_b2b3", dq[3], 1);
      for (int n = 0; n < 50 && busy; n++) @(negedge clk);
      @(negedge clk);

      @(posedge clk) #1;
      cnt[5:0] = 6'd31;
      fmt[2:0] = 3'b001;
      a[31:0]  = 32'h1;
      req      = 2'b01;
      @(posedge clk) #1;
      req = '0;
      repeat (4) @(negedge clk);
      check("wait_busy", busy, 1);
      #2 arst = 1'b1;
      #1;
      check("ar_busy", busy, 0);
      check("ar_done", done, 0);
      check("ar_go", sh_go, 0);
      @(negedge clk);
      @(posedge clk) #1;
      arst = 1'b0;
      run_op(1, 3'b001, 6'd4, 32'h0000_0001, 32'h0000_0010, 8);
      run_op(0, 3'b000, 6'd0, 32'hCAFE_0000, 32'hCAFE_0000, 3);

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule
